// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the byte-wide RAM/IO port between instruction fetch and
//            memory access, tags returning read bytes and stalls IO writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        mem_req_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_dout_i,
  input  logic        io_buffer_full_i,
  input  logic [7:0]  ram_din_i,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  output logic        if_gnt_o,
  output logic        mem_gnt_o,
  output logic        if_dvalid_o,
  output logic        mem_dvalid_o,
  output logic        mem_wait_o,
  output logic [7:0]  din_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IF   = 2'd1,
    ST_MEM  = 2'd2
  } owner_t;

  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   r_last_mem;
  logic   w_last_mem_nxt;
  logic   r_pend_if;
  logic   r_pend_mem;
  logic   w_own_if;
  logic   w_own_mem;
  logic   w_io_hit;

  assign w_own_if  = (r_owner == ST_IF);
  assign w_own_mem = (r_owner == ST_MEM);
  assign w_io_hit  = (mem_addr_i[17:16] == IO_HI);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner    <= ST_IDLE;
      r_last_mem <= 1'b0;
      r_pend_if  <= 1'b0;
      r_pend_mem <= 1'b0;
    end else if (rdy) begin
      r_owner    <= w_owner_nxt;
      r_last_mem <= w_last_mem_nxt;
      r_pend_if  <= w_own_if & if_req_i;
      r_pend_mem <= w_own_mem & mem_req_i & ~mem_wr_i;
    end
  end

  // Ownership is never handed over directly; every release passes through IDLE.
  always_comb begin
    w_owner_nxt    = r_owner;
    w_last_mem_nxt = r_last_mem;
    case (r_owner)
      ST_IDLE: begin
        if (if_req_i && mem_req_i) begin
          if (r_last_mem) begin
            w_owner_nxt    = ST_IF;
            w_last_mem_nxt = 1'b0;
          end else begin
            w_owner_nxt    = ST_MEM;
            w_last_mem_nxt = 1'b1;
          end
        end else if (if_req_i) begin
          w_owner_nxt    = ST_IF;
          w_last_mem_nxt = 1'b0;
        end else if (mem_req_i) begin
          w_owner_nxt    = ST_MEM;
          w_last_mem_nxt = 1'b1;
        end
      end
      ST_IF: begin
        if (!if_req_i) w_owner_nxt = ST_IDLE;
      end
      ST_MEM: begin
        if (!mem_req_i) w_owner_nxt = ST_IDLE;
      end
      default: w_owner_nxt = ST_IDLE;
    endcase
  end

  assign mem_wait_o = w_own_mem & mem_wr_i & w_io_hit & io_buffer_full_i;

  always_comb begin
    ram_a_o    = 32'd0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'd0;
    if (w_own_if) begin
      ram_a_o = if_addr_i;
    end else if (w_own_mem) begin
      ram_a_o    = mem_addr_i;
      ram_dout_o = mem_dout_i;
      ram_wr_o   = mem_wr_i & ~mem_wait_o & rdy;
    end
  end

  assign if_gnt_o     = w_own_if;
  assign mem_gnt_o    = w_own_mem;
  assign if_dvalid_o  = r_pend_if;
  assign mem_dvalid_o = r_pend_mem;
  assign din_o        = ram_din_i;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM/IO port between the instruction-fetch stage (read-only) and the memory-access stage (read/write). It sits downstream of both stages and drives the RAM bus directly. It tracks which requester owns each returning read byte and holds MEM writes to the IO region while the IO buffer is full. Ownership is non-preemptive and round-robin on ties; the first tie after reset goes to MEM.

## Interface
- IO_HI, default 2'b11: value of addr[17:16] that marks the IO region.
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (reset when 0).
- rdy  input  1  global enable; 0 freezes all state, and RAM writes are suppressed.
- if_req_i  input  1  IF requests the bus; held high for the whole multi-byte transaction.
- if_addr_i  input  32  IF byte read address; valid while if_gnt_o=1.
- mem_req_i  input  1  MEM requests the bus; held for the whole transaction.
- mem_wr_i  input  1  MEM write strobe for the current byte.
- mem_addr_i  input  32  MEM byte address.
- mem_dout_i  input  8  MEM write data.
- io_buffer_full_i  input  1  IO output buffer full.
- ram_din_i  input  8  RAM read data; returned one cycle after the address.
- ram_a_o  output  32  RAM address.
- ram_wr_o  output  1  RAM write enable.
- ram_dout_o  output  8  RAM write data.
- if_gnt_o  output  1  IF currently owns the bus.
- mem_gnt_o  output  1  MEM currently owns the bus.
- if_dvalid_o  output  1  ram_din_i this cycle belongs to an IF read.
- mem_dvalid_o  output  1  ram_din_i this cycle belongs to a MEM read.
- mem_wait_o  output  1  MEM write is held for IO backpressure; MEM must keep its address, data and wr unchanged.
- din_o  output  8  ram_din_i passed through unchanged.

## Operation
- State: owner ∈ {IDLE, IF_OWN, MEM_OWN}, last_owner ∈ {IF, MEM}, rd_pend_if, rd_pend_mem.
- IDLE:
  - Only one request: go to that owner.
  - Both requests: grant the one that is not last_owner.
- IF_OWN → IDLE when if_req_i=0. MEM_OWN → IDLE when mem_req_i=0. last_owner updates on every grant.
- No direct owner-to-owner handover; one IDLE cycle always separates owners.
- if_gnt_o = (owner==IF_OWN). mem_gnt_o = (owner==MEM_OWN). Both are decoded from the registered owner.
- Bus mux (combinational from owner):
  - IF_OWN: ram_a_o = if_addr_i, ram_wr_o = 0, ram_dout_o = 0.
  - MEM_OWN: ram_a_o = mem_addr_i, ram_dout_o = mem_dout_i, ram_wr_o = mem_wr_i & ~mem_wait_o & rdy.
  - IDLE: all zero.
- mem_wait_o = MEM_OWN & mem_wr_i & (mem_addr_i[17:16]==IO_HI) & io_buffer_full_i.
- Read tracking, registered on each edge with rdy=1:
  - rd_pend_if ← IF_OWN & if_req_i.
  - rd_pend_mem ← MEM_OWN & mem_req_i & ~mem_wr_i.
  - if_dvalid_o = rd_pend_if; mem_dvalid_o = rd_pend_mem.
- Last byte after release: a read issued in the final owned cycle still produces dvalid in the next cycle, even though the owner is then IDLE.
- rdy=0: owner, last_owner and pend flags hold; ram_wr_o is 0.
- Reset (rst=0 at edge):
  - owner = IDLE, last_owner = IF, pend flags = 0.
  - Every output is 0: ram_a_o, ram_wr_o, ram_dout_o, gnts, dvalids, mem_wait_o. din_o is a pass-through.
  - Reset mid-transaction aborts it and drops any pending dvalid.

## Timing
- Grant latency: req rises in cycle t with owner IDLE → gnt high and address on the bus in t+1 → read data with dvalid in t+2.
- Owned bus: one byte per cycle, back-to-back.
- Release: req falls in cycle t → gnt low in t+1 (IDLE) → next owner's gnt in t+2 at the earliest.
- IO write under backpressure: the write is issued in the first cycle with mem_wait_o=0.
- No combinational path from ram_din_i to any control output.

## Test plan
- Reset then single IF read: rst=0 for 2 cycles, then if_req_i=1, if_addr_i=0x100 for 4 cycles.
  - gnt at cycle 1; ram_a_o shows 0x100..0x103 as IF steps the address.
  - if_dvalid_o high in cycles 2–5; all outputs are 0 during reset.
- Simultaneous first requests: both req at cycle 0.
  - mem_gnt_o=1 at cycle 1.
  - MEM releases at cycle 3 → IDLE at 4, if_gnt_o=1 at 5.
- Second tie with last_owner=MEM: IF is granted first.
- MEM SW to 0x30000 with io_buffer_full_i=1 for 3 cycles:
  - mem_wait_o=1 and ram_wr_o=0 for those cycles.
  - Byte written (ram_wr_o=1, ram_dout_o = MEM data) in the cycle full drops.
- Tail read: MEM reads 0x2000 and drops req in the same cycle.
  - mem_dvalid_o=1 next cycle with owner IDLE.
  - if_dvalid_o stays 0 throughout.
- rdy=0 for 2 cycles mid-IF read: owner and pend flags hold, ram_wr_o=0; the read resumes with correct dvalid alignment. Then rst=0 mid-MEM write: gnt, wr and dvalid are all 0 next cycle.
